// File: rtl/mem_control_pkg.sv
// Shared opcodes, width codes, region decode helpers and the store byte-mask
// rule for the RV32 memory stage.
package mem_control_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = FNC_LB;
  localparam logic [2:0] FNC_SH  = FNC_LH;
  localparam logic [2:0] FNC_SW  = FNC_LW;

  localparam logic [3:0] REG_IO   = 4'b1000;
  localparam logic [3:0] REG_DUAL = 4'b0011;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_DMEM = 2'd1,
    SRC_IO   = 2'd2
  } load_src_e;

  // 0011 aliases both data and instruction memory.
  function automatic logic in_dmem(input logic [3:0] nib);
    in_dmem = (!nib[3] && nib[1:0] == 2'b01) || (nib == REG_DUAL);
  endfunction

  function automatic logic in_imem(input logic [3:0] nib);
    in_imem = (nib[3:1] == 3'b001);
  endfunction

  function automatic logic in_io(input logic [3:0] nib);
    in_io = (nib == REG_IO);
  endfunction

  function automatic logic [3:0] base_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      FNC_SB:  base_mask = 4'b0001 << off;
      FNC_SH:  base_mask = off[0] ? 4'b0000 : (4'b0011 << off);
      FNC_SW:  base_mask = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: base_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_control_load_extend.sv
// Selects the returned read word, aligns DMEM words by byte offset and
// sign/zero-extends according to the registered load width.
module mem_control_load_extend
  import mem_control_pkg::*;
(
  input  load_src_e   src,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] dmem_dout,
  input  logic [31:0] io_dout,
  output logic [31:0] load_data
);

  logic [31:0] word;

  always_comb begin
    word = 32'd0;
    case (src)
      SRC_DMEM: word = dmem_dout >> {off, 3'b000};
      SRC_IO:   word = io_dout;
      default:  word = 32'd0;
    endcase
  end

  always_comb begin
    load_data = word;
    case (funct3)
      FNC_LB:  load_data = {{24{word[7]}}, word[7:0]};
      FNC_LH:  load_data = {{16{word[15]}}, word[15:0]};
      FNC_LBU: load_data = {24'd0, word[7:0]};
      FNC_LHU: load_data = {16'd0, word[15:0]};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/mem_control.sv
// Memory-stage decoder: combinational region decode, byte-lane write masks and
// store steering, plus a one-cycle registered stage for load return alignment.
module mem_control
  import mem_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] rd2,
  input  logic [31:0] pc,
  input  logic        haz_ena,
  input  logic [31:0] dmem_dout,
  input  logic [31:0] io_dout,
  output logic        dmem_en,
  output logic [3:0]  dmem_wr_en,
  output logic [3:0]  imem_wr_en,
  output logic [3:0]  io_trans,
  output logic        io_recv,
  output logic [31:0] mem_in,
  output logic [31:0] load_data
);

  logic [3:0] nib;
  logic [1:0] off;
  logic       is_load;
  logic       is_store;
  logic       r_dmem;
  logic       r_imem;
  logic       r_io;
  logic [3:0] mask;

  assign nib      = addr[31:28];
  assign off      = addr[1:0];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign r_dmem   = in_dmem(nib);
  assign r_imem   = in_imem(nib);
  assign r_io     = in_io(nib);
  assign mask     = base_mask(funct3, off);

  always_comb begin
    dmem_en    = 1'b0;
    io_recv    = 1'b0;
    dmem_wr_en = 4'b0000;
    imem_wr_en = 4'b0000;
    io_trans   = 4'b0000;
    if (haz_ena && is_load) begin
      dmem_en = r_dmem;
      io_recv = r_io;
    end else if (haz_ena && is_store) begin
      dmem_wr_en = r_dmem ? mask : 4'b0000;
      imem_wr_en = (r_imem && pc[30]) ? mask : 4'b0000;
      io_trans   = r_io ? mask : 4'b0000;
    end
  end

  // IO registers take the raw word; memories need the data on the addressed lanes.
  assign mem_in = (is_store && r_io) ? rd2 : (rd2 << {off, 3'b000});

  load_src_e  src_reg, src_next;
  logic [2:0] funct3_reg;
  logic [1:0] off_reg;

  always_comb begin
    src_next = SRC_NONE;
    if (dmem_en)      src_next = SRC_DMEM;
    else if (io_recv) src_next = SRC_IO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg    <= SRC_NONE;
      funct3_reg <= 3'd0;
      off_reg    <= 2'd0;
    end else begin
      src_reg    <= src_next;
      funct3_reg <= funct3;
      off_reg    <= off;
    end
  end

  mem_control_load_extend u_load_extend (
    .src       (src_reg),
    .funct3    (funct3_reg),
    .off       (off_reg),
    .dmem_dout (dmem_dout),
    .io_dout   (io_dout),
    .load_data (load_data)
  );

  logic unused_bits;
  assign unused_bits = ^{addr[27:2], pc[31], pc[29:0]};

endmodule

// File: tb/tb_mem_control.sv
// Directed bench: a table of request-side vectors plus hand sequences for the
// registered load return path, back-to-back loads and reset.
module tb_mem_control;
  import mem_control_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr, rd2, pc;
  logic        haz_ena;
  logic [31:0] dmem_dout, io_dout;
  logic        dmem_en, io_recv;
  logic [3:0]  dmem_wr_en, imem_wr_en, io_trans;
  logic [31:0] mem_in, load_data;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .addr(addr),
    .rd2(rd2), .pc(pc), .haz_ena(haz_ena), .dmem_dout(dmem_dout),
    .io_dout(io_dout), .dmem_en(dmem_en), .dmem_wr_en(dmem_wr_en),
    .imem_wr_en(imem_wr_en), .io_trans(io_trans), .io_recv(io_recv),
    .mem_in(mem_in), .load_data(load_data)
  );

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] p;
    logic        hz;
    logic        e_den;
    logic [3:0]  e_dwr;
    logic [3:0]  e_iwr;
    logic [3:0]  e_iot;
    logic        e_ior;
    logic [31:0] e_min;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [6:0] op, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] d, logic [31:0] p, logic hz, logic e_den,
                              logic [3:0] e_dwr, logic [3:0] e_iwr, logic [3:0] e_iot,
                              logic e_ior, logic [31:0] e_min);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.a = a; v.d = d; v.p = p; v.hz = hz;
    v.e_den = e_den; v.e_dwr = e_dwr; v.e_iwr = e_iwr; v.e_iot = e_iot;
    v.e_ior = e_ior; v.e_min = e_min;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    end
  endtask

  // Issue a request at the falling edge; after the capturing edge a store to
  // DMEM is driven so the returning load is checked against later traffic.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic rst_v);
    @(negedge clk);
    opcode = op; funct3 = f3; addr = a; haz_ena = 1'b1; rst = rst_v;
    @(posedge clk);
    #1;
    rst = 1'b0; opcode = OPC_STORE; funct3 = FNC_SW; addr = 32'h1000_0000; rd2 = 32'hDEAD_BEEF;
  endtask

  task automatic ret(input string n, input logic [31:0] dd, input logic [31:0] id,
                     input logic [31:0] exp);
    dmem_dout = dd; io_dout = id;
    @(negedge clk);
    chk(n, load_data, exp);
    $display("load %s: load_data=0x%08h", n, load_data);
  endtask

  initial begin
    rst = 1'b1; opcode = OPC_LOAD; funct3 = FNC_LW; addr = 32'h1000_0000;
    rd2 = 32'h7a; pc = 32'h0; haz_ena = 1'b1;
    dmem_dout = 32'hFFFF_FFFF; io_dout = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_load_data", load_data, 32'h0);
    rst = 1'b0;

    //          name         op         f3       addr          rd2    pc            hz den  dwr     iwr     iot     ior  mem_in
    vecs.push_back(mk("lb_io",   OPC_LOAD,  FNC_LB,  32'h8000_0010, 32'h7a, 32'h0,        1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 32'h0000_007a));
    vecs.push_back(mk("lw_io",   OPC_LOAD,  FNC_LW,  32'h8000_0020, 32'h7a, 32'h0,        1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 32'h0000_007a));
    vecs.push_back(mk("lh_dm",   OPC_LOAD,  FNC_LH,  32'h1000_0002, 32'h7a, 32'h0,        1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 32'h007a_0000));
    vecs.push_back(mk("lbu_dm",  OPC_LOAD,  FNC_LBU, 32'h1000_0003, 32'h7a, 32'h0,        1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 32'h7a00_0000));
    vecs.push_back(mk("lhu_dm5", OPC_LOAD,  FNC_LHU, 32'h5000_0000, 32'h7a, 32'h0,        1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0000_007a));
    vecs.push_back(mk("lw_dual", OPC_LOAD,  FNC_LW,  32'h3000_0000, 32'h7a, 32'h0,        1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0000_007a));
    vecs.push_back(mk("sw_io",   OPC_STORE, FNC_SW,  32'h8000_0018, 32'h7a, 32'h0,        1, 0, 4'b0000, 4'b0000, 4'b1111, 0, 32'h0000_007a));
    vecs.push_back(mk("sb_io",   OPC_STORE, FNC_SB,  32'h8000_0004, 32'h7a, 32'h0,        1, 0, 4'b0000, 4'b0000, 4'b0001, 0, 32'h0000_007a));
    vecs.push_back(mk("sb_io3",  OPC_STORE, FNC_SB,  32'h8000_0003, 32'h7a, 32'h0,        1, 0, 4'b0000, 4'b0000, 4'b1000, 0, 32'h0000_007a));
    vecs.push_back(mk("sh_io2",  OPC_STORE, FNC_SH,  32'h8000_0002, 32'h7a, 32'h0,        1, 0, 4'b0000, 4'b0000, 4'b1100, 0, 32'h0000_007a));
    vecs.push_back(mk("sb_dm3",  OPC_STORE, FNC_SB,  32'h1000_0003, 32'h7a, 32'h0,        1, 0, 4'b1000, 4'b0000, 4'b0000, 0, 32'h7a00_0000));
    vecs.push_back(mk("sh_dm2",  OPC_STORE, FNC_SH,  32'h1000_0002, 32'h7a, 32'h0,        1, 0, 4'b1100, 4'b0000, 4'b0000, 0, 32'h007a_0000));
    vecs.push_back(mk("sh_mis",  OPC_STORE, FNC_SH,  32'h1000_0001, 32'h7a, 32'h0,        1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0000_7a00));
    vecs.push_back(mk("sw_mis",  OPC_STORE, FNC_SW,  32'h1000_0002, 32'h7a, 32'h0,        1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h007a_0000));
    vecs.push_back(mk("sw_im_p", OPC_STORE, FNC_SW,  32'h3000_0000, 32'h7a, 32'h4000_0000, 1, 0, 4'b1111, 4'b1111, 4'b0000, 0, 32'h0000_007a));
    vecs.push_back(mk("sw_im_0", OPC_STORE, FNC_SW,  32'h3000_0000, 32'h7a, 32'h0,        1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 32'h0000_007a));
    vecs.push_back(mk("sb_im2",  OPC_STORE, FNC_SB,  32'h2000_0001, 32'h7a, 32'h4000_0000, 1, 0, 4'b0000, 4'b0010, 4'b0000, 0, 32'h0000_7a00));
    vecs.push_back(mk("sb_none", OPC_STORE, FNC_SB,  32'h0000_0000, 32'h7a, 32'h4000_0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0000_007a));
    vecs.push_back(mk("squash",  OPC_STORE, FNC_SB,  32'h8000_0004, 32'h7a, 32'h4000_0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0000_007a));
    vecs.push_back(mk("sq_load", OPC_LOAD,  FNC_LW,  32'h1000_0000, 32'h7a, 32'h0,        0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0000_007a));
    vecs.push_back(mk("rtype",   7'b0110011, FNC_SW, 32'h1000_0000, 32'h7a, 32'h4000_0000, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 32'h0000_007a));

    foreach (vecs[i]) begin
      @(negedge clk);
      opcode = vecs[i].op; funct3 = vecs[i].f3; addr = vecs[i].a;
      rd2 = vecs[i].d; pc = vecs[i].p; haz_ena = vecs[i].hz;
      #1;
      chk({vecs[i].name, ".dmem_en"},    {31'd0, dmem_en},    {31'd0, vecs[i].e_den});
      chk({vecs[i].name, ".dmem_wr_en"}, {28'd0, dmem_wr_en}, {28'd0, vecs[i].e_dwr});
      chk({vecs[i].name, ".imem_wr_en"}, {28'd0, imem_wr_en}, {28'd0, vecs[i].e_iwr});
      chk({vecs[i].name, ".io_trans"},   {28'd0, io_trans},   {28'd0, vecs[i].e_iot});
      chk({vecs[i].name, ".io_recv"},    {31'd0, io_recv},    {31'd0, vecs[i].e_ior});
      chk({vecs[i].name, ".mem_in"},     mem_in,              vecs[i].e_min);
      $display("vec %s: den=%b dwr=%b iwr=%b iot=%b ior=%b mem_in=0x%08h",
               vecs[i].name, dmem_en, dmem_wr_en, imem_wr_en, io_trans, io_recv, mem_in);
    end

    issue(OPC_LOAD, FNC_LB, 32'h1000_0001, 1'b0);
    ret("lb_dm1", 32'h0000_F400, 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    issue(OPC_LOAD, FNC_LBU, 32'h1000_0001, 1'b0);
    ret("lbu_dm1", 32'h0000_F400, 32'hFFFF_FFFF, 32'h0000_00F4);
    issue(OPC_LOAD, FNC_LH, 32'h1000_0002, 1'b0);
    ret("lh_dm2", 32'h8001_0000, 32'hFFFF_FFFF, 32'hFFFF_8001);
    issue(OPC_LOAD, FNC_LHU, 32'h1000_0002, 1'b0);
    ret("lhu_dm2", 32'h8001_0000, 32'hFFFF_FFFF, 32'h0000_8001);
    issue(OPC_LOAD, FNC_LW, 32'h1000_0000, 1'b0);
    ret("lw_dm", 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678);
    issue(OPC_LOAD, FNC_LB, 32'h8000_0003, 1'b0);
    ret("lb_io3", 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_FF80);
    issue(OPC_LOAD, FNC_LW, 32'h8000_0000, 1'b0);
    ret("lw_io", 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'hCAFE_F00D);
    issue(OPC_STORE, FNC_SW, 32'h1000_0000, 1'b0);
    ret("after_store", 32'h1234_5678, 32'hCAFE_F00D, 32'h0);
    issue(OPC_LOAD, FNC_LB, 32'h1000_0001, 1'b1);
    ret("reset_drop", 32'h0000_F400, 32'hFFFF_FFFF, 32'h0);

    // Back-to-back: second load is presented while the first one returns.
    @(negedge clk);
    opcode = OPC_LOAD; funct3 = FNC_LBU; addr = 32'h1000_0003; haz_ena = 1'b1;
    @(posedge clk);
    #1;
    funct3 = FNC_LH; addr = 32'h1000_0000; dmem_dout = 32'hAB00_0000;
    @(negedge clk);
    chk("b2b_first", load_data, 32'h0000_00AB);
    $display("load b2b_first: load_data=0x%08h", load_data);
    @(posedge clk);
    #1;
    opcode = 7'd0; dmem_dout = 32'h0000_FF80;
    @(negedge clk);
    chk("b2b_second", load_data, 32'hFFFF_FF80);
    $display("load b2b_second: load_data=0x%08h", load_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
